// File: rtl/pool_job_sched.sv
// ---------------------------------------------------------------------------
// pool_job_sched
//
// Job scheduler for the pooling datapath. Jobs ({flen, inch}) are pushed into
// a small FIFO. While run_en is high, the scheduler pops one job at a time and
// runs it through the datapath handshake:
//   IDLE -> RST (pool_rstn low for RST_CYC cycles) -> START (one-cycle
//   pool_start) -> WAIT (until pool_done) -> DONE (count job) -> IDLE
//
// Optional feature (macro POOL_SCHED_TIMEOUT_EN):
//   When defined, WAIT is bounded by TIMEOUT_CYC cycles. On expiry the job is
//   abandoned, err_timeout is set, and jobs_done is not incremented. When the
//   macro is undefined, no counter is built and err_timeout is tied to 0.
//
// Parameters
//   DEPTH       job-queue entries (power of 2, 2..16)
//   RST_CYC     cycles pool_rstn is held low before each job (>= 1)
//   TIMEOUT_CYC maximum WAIT cycles per job (timeout build only)
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   job_wr              push {job_flen, job_inch} when high
//   job_flen, job_inch  job descriptor fields
//   run_en              dispatch enable (current job always finishes)
//   err_clr             clears err_ovf / err_timeout (a same-cycle set wins)
//   pool_done           completion pulse from the datapath (honoured in WAIT)
//   pool_start          one-cycle start pulse to the datapath
//   pool_rstn           active-low datapath reset, low only in RST
//   Flen, num_INCH      descriptor of the job being / last dispatched
//   job_full, level     queue full flag and occupancy
//   busy                high whenever the FSM is not IDLE
//   jobs_done           completed-job counter (wraps at 256)
//   err_ovf             sticky: a push was dropped because the queue was full
//   err_timeout         sticky: a job exceeded TIMEOUT_CYC WAIT cycles
// ---------------------------------------------------------------------------
module pool_job_sched #(
  parameter int DEPTH       = 4,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     job_wr,
  input  logic [5:0]               job_flen,
  input  logic [8:0]               job_inch,
  input  logic                     run_en,
  input  logic                     err_clr,
  input  logic                     pool_done,
  output logic                     pool_start,
  output logic                     pool_rstn,
  output logic [5:0]               Flen,
  output logic [8:0]               num_INCH,
  output logic                     job_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [7:0]               jobs_done,
  output logic                     err_ovf,
  output logic                     err_timeout
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [LW-1:0]  DEPTH_L  = LW'(DEPTH);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pool_job_sched: DEPTH must be a power of 2 in 2..16");
  end
  if (RST_CYC < 1) begin : g_bad_rst_cyc
    $error("pool_job_sched: RST_CYC must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("pool_job_sched: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RST,
    START,
    WAIT,
    DONE
  } state_t;

  state_t         state;
  logic [14:0]    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [RCW-1:0] rst_cnt;
  logic           pop;
  logic           push;
  logic           ovf_set;

  // A pop frees a slot in the same cycle, so a push at full is still taken
  // when it coincides with a dispatch.
  assign pop      = (state == IDLE) && run_en && (level != '0);
  assign job_full = (level == DEPTH_L);
  assign push     = job_wr && (!job_full || pop);
  assign ovf_set  = job_wr && !push;
  assign busy     = (state != IDLE);

  // Queue storage needs no reset: the pointers and level define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {job_flen, job_inch};
    end
  end

  // Queue pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow in the clearing cycle keeps it set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_ovf <= 1'b0;
    end else begin
      err_ovf <= ovf_set | (err_ovf & ~err_clr);
    end
  end

`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;

  // pool_done on the final WAIT cycle still completes the job normally.
  assign timeout_hit = (state == WAIT) && !pool_done && (wait_cnt == TO_LAST);

  // Sticky timeout flag; expiry in the clearing cycle keeps it set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit | (err_timeout & ~err_clr);
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  // Dispatch FSM. pool_rstn defaults high and is only pulled low on the way
  // into and during RST, so it rises on the first clock after RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      pool_start <= 1'b0;
      pool_rstn  <= 1'b0;
      Flen       <= '0;
      num_INCH   <= '0;
      jobs_done  <= '0;
      rst_cnt    <= '0;
`ifdef POOL_SCHED_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      pool_rstn  <= 1'b1;
      pool_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state              <= RST;
            pool_rstn          <= 1'b0;
            rst_cnt            <= '0;
            {Flen, num_INCH}   <= mem[rd_ptr];
          end
        end
        RST: begin
          if (rst_cnt == RST_LAST) begin
            state      <= START;
            pool_start <= 1'b1;
          end else begin
            pool_rstn <= 1'b0;
            rst_cnt   <= rst_cnt + RCW'(1);
          end
        end
        START: begin
          state <= WAIT;
`ifdef POOL_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (pool_done) begin
            state <= DONE;
`ifdef POOL_SCHED_TIMEOUT_EN
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
`endif
          end
        end
        DONE: begin
          jobs_done <= jobs_done + 8'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_job_sched.sv
// ---------------------------------------------------------------------------
// tb_pool_job_sched
//
// Self-checking bench for pool_job_sched. Expected dispatches come from a
// queue of accepted jobs; a monitor on the falling edge checks every
// pool_start pulse against the queue head and the length of the preceding
// pool_rstn low phase. A constant table exercises fill/overflow/clear, and
// hand-written sequences cover the multi-cycle corners. Define
// POOL_SCHED_TIMEOUT_EN to build and check the timeout variant.
// ---------------------------------------------------------------------------
module tb_pool_job_sched;

  localparam int DEPTH   = 4;
  localparam int RST_CYC = 2;
`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 100;
`else
  localparam int TIMEOUT_CYC = 65535;
`endif

  logic                   CLK = 1'b0;
  logic                   RESET = 1'b1;
  logic                   job_wr = 1'b0;
  logic [5:0]             job_flen = '0;
  logic [8:0]             job_inch = '0;
  logic                   run_en = 1'b0;
  logic                   err_clr = 1'b0;
  logic                   pool_done = 1'b0;
  logic                   pool_start;
  logic                   pool_rstn;
  logic [5:0]             Flen;
  logic [8:0]             num_INCH;
  logic                   job_full;
  logic [$clog2(DEPTH):0] level;
  logic                   busy;
  logic [7:0]             jobs_done;
  logic                   err_ovf;
  logic                   err_timeout;

  typedef struct {
    logic [5:0] flen;
    logic [8:0] inch;
  } job_t;

  typedef struct {
    bit         wr;
    logic [5:0] flen;
    logic [8:0] inch;
    bit         clr;
    int         exp_level;
    bit         exp_full;
    bit         exp_ovf;
  } vec_t;

  job_t exp_q[$];
  int   exp_done;
  bit   exp_ovf;
  int   n_checks;
  int   n_fail;
  int   rstn_low;
  bit   prev_start;

  pool_job_sched #(
    .DEPTH       (DEPTH),
    .RST_CYC     (RST_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .job_wr      (job_wr),
    .job_flen    (job_flen),
    .job_inch    (job_inch),
    .run_en      (run_en),
    .err_clr     (err_clr),
    .pool_done   (pool_done),
    .pool_start  (pool_start),
    .pool_rstn   (pool_rstn),
    .Flen        (Flen),
    .num_INCH    (num_INCH),
    .job_full    (job_full),
    .level       (level),
    .busy        (busy),
    .jobs_done   (jobs_done),
    .err_ovf     (err_ovf),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Drives one cycle of inputs and updates the queue/flag model.
  task automatic applyStimulus(input bit wr, input logic [5:0] f, input logic [8:0] i,
                               input bit clr, input bit popping = 1'b0);
    bit set;
    set      = 1'b0;
    job_wr   = wr;
    job_flen = f;
    job_inch = i;
    err_clr  = clr;
    if (wr) begin
      if (exp_q.size() < DEPTH || popping) exp_q.push_back('{f, i});
      else set = 1'b1;
    end
    exp_ovf = set | (exp_ovf & ~clr);
    tick();
    job_wr  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic checkIdle();
    checkOutput("level", 32'(level), 32'(exp_q.size()));
    checkOutput("job_full", 32'(job_full), 32'(exp_q.size() == DEPTH));
    checkOutput("err_ovf", 32'(err_ovf), 32'(exp_ovf));
    checkOutput("jobs_done", 32'(jobs_done), 32'(exp_done & 255));
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_pool_start", 32'(pool_start), 32'd0);
    checkOutput("rst_pool_rstn", 32'(pool_rstn), 32'd0);
    checkOutput("rst_Flen", 32'(Flen), 32'd0);
    checkOutput("rst_num_INCH", 32'(num_INCH), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_job_full", 32'(job_full), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_jobs_done", 32'(jobs_done), 32'd0);
    checkOutput("rst_err_ovf", 32'(err_ovf), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
  endtask

  task automatic doReset();
    #1 RESET = 1'b1;
    job_wr = 1'b0; run_en = 1'b0; err_clr = 1'b0; pool_done = 1'b0;
    exp_q.delete();
    exp_done = 0;
    exp_ovf  = 1'b0;
    tick();
    tick();
    #1 RESET = 1'b0;
    tick();
  endtask

  task automatic waitStart(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      if (pool_start) seen = 1'b1;
      else tick();
    end
    checkOutput("start_seen", 32'(seen), 32'd1);
  endtask

  // Answers a started job with pool_done 'delay' cycles after pool_start.
  task automatic finishJob(input int delay);
    repeat (delay) tick();
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    tick();
    exp_done++;
  endtask

  task automatic serviceJob(input int delay);
    bit seen;
    waitStart(seen);
    if (seen) finishJob(delay);
  endtask

  // Every start pulse must follow exactly RST_CYC low cycles of pool_rstn,
  // last a single cycle, and carry the oldest accepted job.
  always @(negedge CLK) begin
    if (RESET) begin
      rstn_low   = 0;
      prev_start = 1'b0;
    end else begin
      if (pool_start) begin
        checkOutput("start_single", 32'(prev_start), 32'd0);
        checkOutput("rstn_low_cycles", 32'(rstn_low), 32'(RST_CYC));
        checkOutput("dispatch_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          checkOutput("dispatch_Flen", 32'(Flen), 32'(exp_q[0].flen));
          checkOutput("dispatch_num_INCH", 32'(num_INCH), 32'(exp_q[0].inch));
          void'(exp_q.pop_front());
        end
        rstn_low = 0;
      end else if (!pool_rstn) begin
        rstn_low++;
      end
      prev_start = pool_start;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    bit   seen;
    int   n;

    vecs[0] = '{1'b1, 6'd1, 9'd1, 1'b0, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 6'd2, 9'd2, 1'b0, 2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 6'd3, 9'd3, 1'b0, 3, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 6'd4, 9'd4, 1'b0, 4, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 6'd5, 9'd5, 1'b0, 4, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 6'd0, 9'd0, 1'b1, 4, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 6'd6, 9'd6, 1'b1, 4, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 6'd0, 9'd0, 1'b1, 4, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 6'd0, 9'd0, 1'b0, 4, 1'b1, 1'b0};

    // Power-on reset values, then pool_rstn rises on the first clock.
    tick();
    tick();
    checkResetValues();
    #1 RESET = 1'b0;
    tick();
    checkOutput("rstn_after_reset", 32'(pool_rstn), 32'd1);
    checkIdle();

    // Single job with pool_done 10 cycles after start; then a stray pool_done.
    $display("[TB] single job");
    doReset();
    applyStimulus(1'b1, 6'd13, 9'd256, 1'b0);
    run_en = 1'b1;
    serviceJob(10);
    run_en = 1'b0;
    checkOutput("single_Flen", 32'(Flen), 32'd13);
    checkOutput("single_num_INCH", 32'(num_INCH), 32'd256);
    checkIdle();
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    tick();
    checkOutput("stray_done_jobs", 32'(jobs_done), 32'd1);
    checkOutput("stray_done_busy", 32'(busy), 32'd0);

    // Fill, overflow and sticky-flag table, then drain in order.
    $display("[TB] fill/overflow table");
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].wr, vecs[k].flen, vecs[k].inch, vecs[k].clr);
      checkOutput("tbl_level", 32'(level), 32'(vecs[k].exp_level));
      checkOutput("tbl_job_full", 32'(job_full), 32'(vecs[k].exp_full));
      checkOutput("tbl_err_ovf", 32'(err_ovf), 32'(vecs[k].exp_ovf));
    end
    run_en = 1'b1;
    repeat (4) serviceJob(3);
    run_en = 1'b0;
    checkIdle();

    // Push at full in the same cycle as a dispatch is accepted.
    $display("[TB] push at full with pop");
    doReset();
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 6'(20 + k), 9'(300 + k), 1'b0);
    run_en = 1'b1;
    applyStimulus(1'b1, 6'd9, 9'd9, 1'b0, 1'b1);
    checkOutput("pushpop_level", 32'(level), 32'(DEPTH));
    checkOutput("pushpop_err_ovf", 32'(err_ovf), 32'd0);
    repeat (DEPTH + 1) serviceJob(2);
    run_en = 1'b0;
    checkIdle();

    // run_en dropped during WAIT: current job completes, next one stays queued.
    $display("[TB] run_en drop");
    doReset();
    applyStimulus(1'b1, 6'd7, 9'd100, 1'b0);
    applyStimulus(1'b1, 6'd8, 9'd200, 1'b0);
    run_en = 1'b1;
    waitStart(seen);
    tick();
    tick();
    run_en = 1'b0;
    if (seen) finishJob(3);
    repeat (4) tick();
    checkIdle();
    checkOutput("hold_Flen", 32'(Flen), 32'd7);
    checkOutput("hold_num_INCH", 32'(num_INCH), 32'd100);

    // Asynchronous reset in WAIT with queued jobs.
    $display("[TB] reset mid-job");
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 6'(40 + k), 9'(400 + k), 1'b0);
    run_en = 1'b1;
    waitStart(seen);
    repeat (3) tick();
    #1 RESET = 1'b1;
    #1 checkResetValues();
    run_en = 1'b0;
    exp_q.delete();
    exp_done = 0;
    exp_ovf  = 1'b0;
    tick();
    #1 RESET = 1'b0;
    tick();
    checkOutput("midrst_rstn", 32'(pool_rstn), 32'd1);
    checkIdle();

`ifdef POOL_SCHED_TIMEOUT_EN
    $display("[TB] timeout");
    doReset();
    applyStimulus(1'b1, 6'd11, 9'd22, 1'b0);
    run_en = 1'b1;
    waitStart(seen);
    run_en = 1'b0;
    repeat (TIMEOUT_CYC) tick();
    checkOutput("timeout_early", 32'(err_timeout), 32'd0);
    checkOutput("timeout_busy_wait", 32'(busy), 32'd1);
    tick();
    checkOutput("timeout_flag", 32'(err_timeout), 32'd1);
    checkIdle();
    applyStimulus(1'b0, 6'd0, 9'd0, 1'b1);
    checkOutput("timeout_clr", 32'(err_timeout), 32'd0);
`else
    $display("[TB] unbounded wait");
    doReset();
    applyStimulus(1'b1, 6'd11, 9'd22, 1'b0);
    run_en = 1'b1;
    waitStart(seen);
    run_en = 1'b0;
    repeat (150) tick();
    checkOutput("wait_still_busy", 32'(busy), 32'd1);
    checkOutput("no_timeout_flag", 32'(err_timeout), 32'd0);
    if (seen) finishJob(0);
    checkIdle();
`endif

    // Randomized rounds against the queue model.
    $display("[TB] random rounds");
    doReset();
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        applyStimulus(1'b1, 6'($urandom), 9'($urandom), ($urandom_range(0, 3) == 0));
      end
      checkIdle();
      n = exp_q.size();
      run_en = 1'b1;
      repeat (n) serviceJob($urandom_range(1, 8));
      run_en = 1'b0;
      checkIdle();
      applyStimulus(1'b0, 6'd0, 9'd0, 1'b1);
    end

    // jobs_done wraps 255 -> 0.
    $display("[TB] jobs_done wrap");
    doReset();
    run_en = 1'b1;
    for (int k = 0; k < 255; k++) begin
      applyStimulus(1'b1, 6'($urandom), 9'($urandom), 1'b0);
      serviceJob(1);
    end
    checkOutput("jobs_done_255", 32'(jobs_done), 32'd255);
    applyStimulus(1'b1, 6'd1, 9'd1, 1'b0);
    serviceJob(1);
    run_en = 1'b0;
    checkOutput("jobs_done_wrap", 32'(jobs_done), 32'd0);
    checkIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
